// File: rtl/adpll_gain_sched.sv
// Reference select/sync, lock detection and kp/ki scheduling for the ring ADPLL; `ADPLL_ERR_PEAK_EN adds err_peak_o.
// Latency: ref_clk_o 1 cycle after the mux, ref_edge 1 cycle after its rise; state and gains update on the same edge.
// Backpressure: none; the block free-runs and samples error_i only on ref_edge cycles.
module adpll_gain_sched #(
  parameter int ACCUM_WIDTH    = 12,
  parameter int ERR_WIDTH      = 8,
  parameter int KP_WIDTH       = 6,
  parameter int KI_WIDTH       = 9,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_TOL       = 2,
  parameter int UNLOCK_TOL     = 8,
  parameter int LOCK_COUNT     = 16,
  parameter int UNLOCK_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   fpga_clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   ref_sel_i,
  input  logic [ACCUM_WIDTH-1:0] ref_k_i,
  input  logic                   ext_ref_i,
  input  logic [ERR_WIDTH-1:0]   error_i,
  input  logic [KP_WIDTH-1:0]    kp_acq_i,
  input  logic [KI_WIDTH-1:0]    ki_acq_i,
  input  logic [KP_WIDTH-1:0]    kp_trk_i,
  input  logic [KI_WIDTH-1:0]    ki_trk_i,
  output logic                   ref_clk_o,
  output logic                   adpll_enable_o,
  output logic [KP_WIDTH-1:0]    kp_o,
  output logic [KI_WIDTH-1:0]    ki_o,
  output logic                   locked_o,
  output logic                   ref_lost_o,
  output logic [1:0]             state_o
`ifdef ADPLL_ERR_PEAK_EN
  ,
  output logic [ERR_WIDTH-2:0]   err_peak_o
`endif
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int MCW = $clog2(UNLOCK_COUNT + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LCW-1:0]       LOCK_MAX    = LCW'(LOCK_COUNT);
  localparam logic [LCW-1:0]       LOCK_LAST   = LCW'(LOCK_COUNT - 1);
  localparam logic [MCW-1:0]       MISS_MAX    = MCW'(UNLOCK_COUNT);
  localparam logic [MCW-1:0]       MISS_LAST   = MCW'(UNLOCK_COUNT - 1);
  localparam logic [WDW-1:0]       WD_MAX      = WDW'(TIMEOUT_CYCLES);
  localparam logic [ERR_WIDTH-2:0] LOCK_TOL_E  = (ERR_WIDTH-1)'(LOCK_TOL);
  localparam logic [ERR_WIDTH-2:0] UNLOCK_TOL_E = (ERR_WIDTH-1)'(UNLOCK_TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    TRACK   = 2'b10,
    LOST    = 2'b11
  } state_t;

  state_t                 state_q, state_nxt;
  logic [ACCUM_WIDTH-1:0] acc_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sel_q, ref_d_q, ref_edge_q;
  logic                   sel_change;
  logic [ERR_WIDTH-1:0]   err_mag;
  logic [ERR_WIDTH-2:0]   abs_err;
  logic                   lock_hit, miss_hit, timeout, cnt_clr;
  logic [LCW-1:0]         lock_cnt;
  logic [MCW-1:0]         miss_cnt;
  logic [WDW-1:0]         wd_cnt;
  logic                   adpll_enable_d, locked_d, ref_lost_d;
  logic [KP_WIDTH-1:0]    kp_d;
  logic [KI_WIDTH-1:0]    ki_d;

  // Reference path: the mux uses the registered select so a select change lines up with sel_change.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q      <= '0;
      sync_q     <= '0;
      sel_q      <= 1'b0;
      ref_clk_o  <= 1'b0;
      ref_d_q    <= 1'b0;
      ref_edge_q <= 1'b0;
    end else begin
      acc_q      <= acc_q + ref_k_i;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_ref_i};
      sel_q      <= ref_sel_i;
      ref_clk_o  <= sel_q ? sync_q[SYNC_STAGES-1] : acc_q[ACCUM_WIDTH-1];
      ref_d_q    <= ref_clk_o;
      ref_edge_q <= ref_clk_o & ~ref_d_q;
    end
  end

  assign sel_change = (ref_sel_i != sel_q);

  // The most-negative code has no positive twin; its magnitude saturates.
  always_comb begin
    err_mag = error_i[ERR_WIDTH-1] ? -error_i : error_i;
    abs_err = err_mag[ERR_WIDTH-1] ? '1 : err_mag[ERR_WIDTH-2:0];
  end

  assign lock_hit = ref_edge_q && (abs_err <= LOCK_TOL_E);
  assign miss_hit = ref_edge_q && (abs_err > UNLOCK_TOL_E);
  assign timeout  = (wd_cnt == WD_MAX) && !ref_edge_q;

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (state_q == IDLE) begin
      if (enable_i) state_nxt = ACQUIRE;
    end else if (!enable_i) begin
      state_nxt = IDLE;
    end else if (sel_change) begin
      state_nxt = ACQUIRE;
    end else if (timeout && (state_q == ACQUIRE || state_q == TRACK)) begin
      state_nxt = LOST;
    end else begin
      case (state_q)
        ACQUIRE: if (lock_hit && lock_cnt == LOCK_LAST) state_nxt = TRACK;
        TRACK:   if (miss_hit && miss_cnt == MISS_LAST) state_nxt = ACQUIRE;
        LOST:    if (ref_edge_q) state_nxt = ACQUIRE;
        default: state_nxt = state_q;
      endcase
    end
  end

  always_comb begin
    adpll_enable_d = 1'b0;
    locked_d       = 1'b0;
    ref_lost_d     = 1'b0;
    kp_d           = kp_acq_i;
    ki_d           = ki_acq_i;
    case (state_nxt)
      ACQUIRE: adpll_enable_d = 1'b1;
      TRACK: begin
        adpll_enable_d = 1'b1;
        locked_d       = 1'b1;
        kp_d           = kp_trk_i;
        ki_d           = ki_trk_i;
      end
      LOST:    ref_lost_d = 1'b1;
      default: adpll_enable_d = 1'b0;
    endcase
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adpll_enable_o <= 1'b0;
      locked_o       <= 1'b0;
      ref_lost_o     <= 1'b0;
      kp_o           <= '0;
      ki_o           <= '0;
    end else begin
      adpll_enable_o <= adpll_enable_d;
      locked_o       <= locked_d;
      ref_lost_o     <= ref_lost_d;
      kp_o           <= kp_d;
      ki_o           <= ki_d;
    end
  end

  assign state_o = state_q;

  // Every state change starts the lock/miss runs afresh.
  assign cnt_clr = (state_q == IDLE) || sel_change || (state_nxt != state_q);

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_cnt <= '0;
      miss_cnt <= '0;
    end else if (cnt_clr) begin
      lock_cnt <= '0;
      miss_cnt <= '0;
    end else if (ref_edge_q) begin
      if (state_q == ACQUIRE)
        lock_cnt <= !lock_hit ? '0 : (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
      if (state_q == TRACK)
        miss_cnt <= !miss_hit ? '0 : (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                         wd_cnt <= '0;
    else if (state_q == IDLE || sel_change || ref_edge_q) wd_cnt <= '0;
    else if (wd_cnt != WD_MAX)                            wd_cnt <= wd_cnt + 1'b1;
  end

`ifdef ADPLL_ERR_PEAK_EN
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      err_peak_o <= '0;
    else if (state_nxt == TRACK && state_q != TRACK)
      err_peak_o <= '0;
    else if (state_q == TRACK && ref_edge_q && abs_err > err_peak_o)
      err_peak_o <= abs_err;
  end
`endif

endmodule

// File: doc/adpll_gain_sched.md
Name: adpll_gain_sched

Overview:
Reference-source and loop-gain controller for the ring ADPLL.
- Generates an internal reference with a phase accumulator, or synchronises the external reference pin, and drives the selected reference to the ADPLL.
- Monitors the ADPLL phase error, detects lock, loss of lock and loss of reference.
- Switches between acquisition and tracking kp/ki, replacing the fixed switch-set gains in the test tops.

Parameters:
ACCUM_WIDTH, 12, internal reference phase-accumulator width.
ERR_WIDTH, 8, signed ADPLL error width.
KP_WIDTH, 6, kp bus width.
KI_WIDTH, 9, ki bus width.
SYNC_STAGES, 2, external-reference synchroniser flops (min 2).
LOCK_TOL, 2, |error| at or below this counts as in-lock.
UNLOCK_TOL, 8, |error| above this counts as a miss while tracking.
LOCK_COUNT, 16, consecutive in-lock ref edges needed to declare lock.
UNLOCK_COUNT, 4, consecutive misses needed to drop lock.
TIMEOUT_CYCLES, 4096, fpga_clk cycles without a ref edge before reference is declared lost.

Ports:
fpga_clk_i  in  1  system clock (258 MHz domain).
rst_n_i  in  1  asynchronous, active-low reset.
enable_i  in  1  loop enable.
ref_sel_i  in  1  0 = internal phase accumulator, 1 = external reference.
ref_k_i  in  ACCUM_WIDTH  phase-accumulator increment.
ext_ref_i  in  1  asynchronous external reference.
error_i  in  ERR_WIDTH  signed ADPLL phase error.
kp_acq_i / ki_acq_i  in  KP_WIDTH / KI_WIDTH  acquisition gains.
kp_trk_i / ki_trk_i  in  KP_WIDTH / KI_WIDTH  tracking gains.
ref_clk_o  out  1  registered selected reference to the ADPLL.
adpll_enable_o  out  1  enable to the ADPLL.
kp_o / ki_o  out  KP_WIDTH / KI_WIDTH  active gains.
locked_o  out  1  high in TRACK.
ref_lost_o  out  1  high in LOST.
state_o  out  2  00 IDLE, 01 ACQUIRE, 10 TRACK, 11 LOST.

Behaviour:
Reset (rst_n_i low, asynchronous): every register clears. This gives the following output and internal values:
- state IDLE, accumulator 0, counters 0.
- ref_clk_o 0, adpll_enable_o 0, locked_o 0, ref_lost_o 0.
- kp_o = 0, ki_o = 0.
Release is synchronous to fpga_clk_i.

Reference path:
- Accumulator adds ref_k_i every cycle, modulo 2^ACCUM_WIDTH; its MSB is the internal reference.
- ext_ref_i passes through SYNC_STAGES flops.
- The mux output is registered into ref_clk_o.
- A rising-edge detector on ref_clk_o gives ref_edge, a one-cycle pulse, one cycle after the ref_clk_o rise.
- ref_sel_i is registered. A change in it is a sel_change event: counters clear and a non-IDLE state goes to ACQUIRE next cycle.

Error magnitude:
- abs_err = |error_i|; the most-negative error saturates to 2^(ERR_WIDTH-1)-1.
- error_i is sampled only on ref_edge cycles.

FSM (registered, one transition per cycle). Priority: enable_i low > sel_change > timeout > error rules.
- IDLE: adpll_enable_o 0, gains = acq. enable_i high -> ACQUIRE.
- ACQUIRE: adpll_enable_o 1, gains = acq.
  - On ref_edge: abs_err <= LOCK_TOL increments lock_cnt (saturating at LOCK_COUNT); otherwise lock_cnt clears.
  - When lock_cnt reaches LOCK_COUNT -> TRACK, and lock_cnt clears.
- TRACK: gains = trk, locked_o 1.
  - On ref_edge: abs_err > UNLOCK_TOL increments miss_cnt; otherwise miss_cnt clears.
  - When miss_cnt reaches UNLOCK_COUNT -> ACQUIRE.
- LOST: adpll_enable_o 0, gains = acq, ref_lost_o 1. The next ref_edge -> ACQUIRE with counters clear.
- Any state except IDLE: enable_i low -> IDLE next cycle.

Watchdog:
- Counts cycles since the last ref_edge and clears on ref_edge.
- Reaching TIMEOUT_CYCLES in ACQUIRE or TRACK -> LOST.
- Saturates; it is inactive in IDLE.
- Simultaneous timeout and ref_edge: the ref_edge wins.

Outputs: kp_o, ki_o, locked_o, ref_lost_o and adpll_enable_o are registered from the next state, so they change on the same edge as state_o.

Optional Feature:
ADPLL_ERR_PEAK_EN
- Defined: adds output err_peak_o (ERR_WIDTH-1 bits).
  - Holds the maximum abs_err sampled on ref_edge while in TRACK.
  - Clears on entry to TRACK and on reset.
- Undefined: the port and register are absent, with no other change.

Test Plan:
- Internal reference, ref_k_i=19, ref_sel_i=0 -> ref_clk_o period 4096/19 cycles (215 or 216, averaging 215.58); state stays IDLE while enable_i=0.
- enable_i=1, error_i=1 constant -> ACQUIRE; TRACK on the cycle after the 16th ref_edge. Check kp_o switches from kp_acq_i=9 to kp_trk_i=3, and locked_o=1.
- In TRACK, error_i=-128 -> abs_err 127. After 4 ref edges -> ACQUIRE. Check that error_i=5 on one edge between misses resets miss_cnt.
- ref_sel_i=1, ext_ref_i held low -> LOST 4096 cycles after the last edge, with adpll_enable_o=0. Toggle ext_ref_i -> ACQUIRE.
- Pulse rst_n_i low for 3 ns mid-TRACK, asynchronous to the clock -> all outputs 0 immediately; IDLE after release.
- With ADPLL_ERR_PEAK_EN, errors 3, -7, 2 in TRACK -> err_peak_o=7; it clears on re-entering TRACK.
